// File: rtl/mmio_slot_master.sv
// mmio_slot_master: single-outstanding MMIO initiator. Decodes the slot from
// req_addr[15:8], drives that slot's select, waits for completion or timeout.
module mmio_slot_master #(
  parameter int NUM_SLOTS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [15:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_rdata,
  output logic [1:0]              rsp_err,
  output logic [NUM_SLOTS-1:0]    chip_select,
  output logic                    read,
  output logic                    write,
  output logic [7:0]              addr,
  output logic [31:0]             wr_data,
  output logic                    transaction_completed,
  input  logic [NUM_SLOTS*32-1:0] rd_data,
  input  logic [NUM_SLOTS-1:0]    wr_done,
  input  logic [NUM_SLOTS-1:0]    rd_done,
  input  logic [NUM_SLOTS-1:0]    slave_error,
  input  logic [NUM_SLOTS-1:0]    decode_error
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [SW-1:0] slot;

  logic        in_range;
  logic        s_wr, s_rd, s_serr, s_derr, hit;
  logic [31:0] s_rdata;

  assign req_ready = (state == IDLE);
  assign in_range  = ({1'b0, req_addr[15:8]} < 9'(NUM_SLOTS));

  // Only the captured slot's status can complete the transaction.
  assign s_wr    = wr_done[slot];
  assign s_rd    = rd_done[slot];
  assign s_serr  = slave_error[slot];
  assign s_derr  = decode_error[slot];
  assign s_rdata = rd_data[slot*32 +: 32];
  assign hit     = s_wr | s_rd | s_serr | s_derr;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state                 <= IDLE;
      count                 <= '0;
      slot                  <= '0;
      rsp_valid             <= 1'b0;
      rsp_rdata             <= '0;
      rsp_err               <= 2'b00;
      chip_select           <= '0;
      read                  <= 1'b0;
      write                 <= 1'b0;
      addr                  <= '0;
      wr_data               <= '0;
      transaction_completed <= 1'b0;
    end else begin
      transaction_completed <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (in_range) begin
              chip_select <= NUM_SLOTS'(1) << req_addr[15:8];
              write       <= req_write;
              read        <= !req_write;
              addr        <= req_addr[7:0];
              wr_data     <= req_wdata;
              count       <= '0;
              slot        <= req_addr[8 +: SW];
              state       <= ISSUE;
            end else begin
              // No slot is touched, so no completion pulse is owed.
              rsp_valid <= 1'b1;
              rsp_err   <= 2'b10;
              rsp_rdata <= '0;
              state     <= RESP;
            end
          end
        end
        ISSUE: begin
          if (hit || (count == CW'(TIMEOUT - 1))) begin
            chip_select           <= '0;
            read                  <= 1'b0;
            write                 <= 1'b0;
            transaction_completed <= 1'b1;
            rsp_valid             <= 1'b1;
            state                 <= RESP;
            if (hit) begin
              rsp_err   <= s_derr ? 2'b10 : (s_serr ? 2'b01 : 2'b00);
              rsp_rdata <= (read && s_rd && !s_derr && !s_serr) ? s_rdata : 32'd0;
            end else begin
              rsp_err   <= 2'b11;
              rsp_rdata <= '0;
            end
          end else if (count != {CW{1'b1}}) begin
            count <= count + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 2'b00;
            addr      <= '0;
            wr_data   <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_slot_master.sv
// Bench for mmio_slot_master: behavioural slot slaves plus a response scoreboard.
module tb_mmio_slot_master;
  localparam int NS = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  logic             req_valid, req_ready, req_write;
  logic [15:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_rdata;
  logic [1:0]       rsp_err;
  logic [NS-1:0]    chip_select;
  logic             read, write, transaction_completed;
  logic [7:0]       addr;
  logic [31:0]      wr_data;
  logic [NS*32-1:0] rd_data;
  logic [NS-1:0]    wr_done, rd_done, slave_error, decode_error, extra_rd;

  mmio_slot_master #(.NUM_SLOTS(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .chip_select(chip_select), .read(read), .write(write), .addr(addr), .wr_data(wr_data),
    .transaction_completed(transaction_completed),
    .rd_data(rd_data), .wr_done(wr_done), .rd_done(rd_done),
    .slave_error(slave_error), .decode_error(decode_error)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] rdata;
    int          lat;
    int          tcs;
  } exp_t;
  exp_t sb[$];

  // Slave modes: 0 normal, 1 rd_done+slave_error, 2 decode_error, 3 silent.
  int   mode[NS];
  int   dly[NS];
  int   st[NS];
  int   cnt[NS];
  logic op_rd[NS];

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NS; i++) begin
        st[i] <= 0; cnt[i] <= 0; op_rd[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NS; i++) begin
        case (st[i])
          0: if (chip_select[i] && (read || write)) begin
               st[i] <= 1; cnt[i] <= 1; op_rd[i] <= read;
             end
          1: if (cnt[i] >= dly[i]) st[i] <= 2; else cnt[i] <= cnt[i] + 1;
          default: if (transaction_completed) st[i] <= 0;
        endcase
      end
    end
  end

  always_comb begin
    wr_done = '0; rd_done = '0; slave_error = '0; decode_error = '0; rd_data = '0;
    for (int i = 0; i < NS; i++) begin
      wr_done[i]      = (st[i] == 2) && (mode[i] == 0) && !op_rd[i];
      rd_done[i]      = ((st[i] == 2) && op_rd[i] && (mode[i] == 0 || mode[i] == 1)) || extra_rd[i];
      slave_error[i]  = (st[i] == 2) && (mode[i] == 1);
      decode_error[i] = (st[i] == 2) && (mode[i] == 2);
      rd_data[i*32 +: 32] = (i == 1) ? 32'h1 : (32'hC0DE_0000 | 32'(i));
    end
  end

  int tc_cnt = 0;
  int cs_cnt = 0;
  always @(negedge clk) begin
    if (transaction_completed === 1'b1) tc_cnt++;
    if (|chip_select) cs_cnt++;
  end

  task automatic do_txn(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                        input logic [NS-1:0] exp_cs, input logic [1:0] e_err,
                        input logic [31:0] e_rd, input int e_lat, input int e_tc,
                        input int hold);
    exp_t e, g;
    int   n, tc0, cs0;
    e.err = e_err; e.rdata = e_rd; e.lat = e_lat; e.tcs = e_tc;
    sb.push_back(e);
    tc0 = tc_cnt; cs0 = cs_cnt;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL req_ready_idle addr=%h got=%b exp=1", a, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    if (exp_cs != '0) begin
      total++;
      if ({chip_select, write, read, addr, wr_data} !== {exp_cs, wr, !wr, a[7:0], wd}) begin
        bad++;
        $display("FAIL bus_phase addr=%h got cs=%b w=%b r=%b a=%h d=%h exp cs=%b w=%b a=%h d=%h",
                 a, chip_select, write, read, addr, wr_data, exp_cs, wr, a[7:0], wd);
      end
    end
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    g = sb.pop_front();
    total++;
    if (rsp_valid !== 1'b1 || n != g.lat) begin
      bad++; $display("FAIL latency addr=%h got=%0d valid=%b exp=%0d", a, n, rsp_valid, g.lat);
    end
    total++;
    if ({rsp_err, rsp_rdata} !== {g.err, g.rdata}) begin
      bad++; $display("FAIL response addr=%h got err=%b data=%h exp err=%b data=%h",
                      a, rsp_err, rsp_rdata, g.err, g.rdata);
    end
    total++;
    if ({chip_select, read, write} !== '0 || transaction_completed !== (g.tcs > 0)) begin
      bad++; $display("FAIL resp_entry addr=%h got cs=%b r=%b w=%b tc=%b exp tc=%0d",
                      a, chip_select, read, write, transaction_completed, g.tcs);
    end
    for (int k = 0; k < hold; k++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({rsp_valid, rsp_err, rsp_rdata, req_ready, transaction_completed} !==
          {1'b1, g.err, g.rdata, 1'b0, 1'b0}) begin
        bad++; $display("FAIL hold_stable k=%0d got v=%b err=%b d=%h rdy=%b tc=%b", k,
                        rsp_valid, rsp_err, rsp_rdata, req_ready, transaction_completed);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b0, 1'b1, 2'b00, 32'd0}) begin
      bad++; $display("FAIL back_to_idle addr=%h got v=%b rdy=%b err=%b d=%h",
                      a, rsp_valid, req_ready, rsp_err, rsp_rdata);
    end
    total++;
    if (tc_cnt - tc0 != g.tcs) begin
      bad++; $display("FAIL tc_pulses addr=%h got=%0d exp=%0d", a, tc_cnt - tc0, g.tcs);
    end
    if (exp_cs == '0) begin
      total++;
      if (cs_cnt != cs0) begin
        bad++; $display("FAIL no_select addr=%h got=%0d exp=0", a, cs_cnt - cs0);
      end
    end
  endtask

  task automatic check_zero_outputs(input string name);
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, chip_select, read, write, addr, wr_data,
         transaction_completed} !== {1'b1, 1'b0, 32'd0, 2'b00, {NS{1'b0}}, 1'b0, 1'b0, 8'd0,
         32'd0, 1'b0}) begin
      bad++;
      $display("FAIL %s got rdy=%b v=%b d=%h err=%b cs=%b r=%b w=%b a=%h wd=%h tc=%b exp all 0, rdy=1",
               name, req_ready, rsp_valid, rsp_rdata, rsp_err, chip_select, read, write, addr,
               wr_data, transaction_completed);
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset_state");
    arst_n = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("after_reset_idle");
  endtask

  task automatic test_write();
    do_txn(1'b1, 16'h0004, 32'h2, 4'b0001, 2'b00, 32'd0, 4, 1, 0);
  endtask

  task automatic test_read();
    extra_rd = 4'b0100;
    do_txn(1'b0, 16'h0110, 32'd0, 4'b0010, 2'b00, 32'h1, 4, 1, 0);
    extra_rd = '0;
  endtask

  task automatic test_errors();
    mode[1] = 1;
    do_txn(1'b0, 16'h0120, 32'd0, 4'b0010, 2'b01, 32'd0, 4, 1, 0);
    mode[1] = 2;
    do_txn(1'b0, 16'h0140, 32'd0, 4'b0010, 2'b10, 32'd0, 4, 1, 0);
    mode[1] = 0;
  endtask

  task automatic test_out_of_range();
    do_txn(1'b0, 16'h0500, 32'd0, 4'b0000, 2'b10, 32'd0, 1, 0, 0);
    do_txn(1'b1, 16'h0400, 32'h55, 4'b0000, 2'b10, 32'd0, 1, 0, 0);
  endtask

  task automatic test_timeout();
    mode[3] = 3;
    do_txn(1'b0, 16'h0300, 32'd0, 4'b1000, 2'b11, 32'd0, TO + 1, 1, 0);
    mode[3] = 0;
  endtask

  task automatic test_late_hit();
    dly[2] = 6;
    do_txn(1'b1, 16'h0208, 32'hDEAD_BEEF, 4'b0100, 2'b00, 32'd0, TO + 1, 1, 0);
    dly[2] = 1;
  endtask

  task automatic test_hold();
    do_txn(1'b0, 16'h0110, 32'd0, 4'b0010, 2'b00, 32'h1, 4, 1, 5);
  endtask

  task automatic test_back_to_back();
    do_txn(1'b0, 16'h0000, 32'd0, 4'b0001, 2'b00, 32'hC0DE_0000, 4, 1, 0);
    do_txn(1'b1, 16'h03FC, 32'h1234_5678, 4'b1000, 2'b00, 32'd0, 4, 1, 0);
    do_txn(1'b0, 16'h0304, 32'd0, 4'b1000, 2'b00, 32'hC0DE_0003, 4, 1, 0);
  endtask

  task automatic test_async_reset();
    mode[3] = 3;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0300; req_wdata = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset_issue");
    @(posedge clk); #1;
    arst_n = 1'b1;
    mode[3] = 0;
    @(posedge clk); #1;
    do_txn(1'b1, 16'h0010, 32'hA5, 4'b0001, 2'b00, 32'd0, 4, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      mode[i] = 0; dly[i] = 1;
    end
    extra_rd = '0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_out_of_range();
    test_timeout();
    test_late_hit();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
